// File: rtl/vga_pkg.sv
// Shared VGA timing constants and counter type for the raster generator
// and the downstream active-region logic.
package vga_pkg;

  // Default 640x480 @ 60 Hz timing (pixels / lines)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 2;

  // Derived defaults
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
  localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

  // Counter width; totals up to 1024 fit
  localparam int CNT_W   = 10;
  localparam int CNT_MAX = 1 << CNT_W;

  typedef logic [CNT_W-1:0] vga_cnt_t;

  // True when lo <= c < hi; done in int so a bound of 1024 still works
  function automatic logic in_window(input vga_cnt_t c, input int lo, input int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_pix_strobe.sv
// Clock divider producing the one-clk pixel strobe. 'tick' is the
// combinational "this edge advances the raster" condition; pix_en is
// its registered image, so it is high in the cycle the new counter
// values are presented.
module pix_strobe
  import vga_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic pix_en
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $fatal(1, "pix_strobe: CLK_DIV must be at least 1");
    end
  endgenerate

  logic [DIV_W-1:0] div_cnt;

  assign tick = (div_cnt == DIV_LAST);

  // Divider count and strobe register; with CLK_DIV=1 the count stays 0
  // and tick is permanently true, so pix_en stays high after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      pix_en  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      pix_en  <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters plus registered sync,
// active and start flags. Counters park at the last pixel of a frame on
// reset so the first strobe presents (0,0) as a fresh frame.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV
) (
  input  logic     clk,
  input  logic     rst_n,
  output vga_cnt_t hcount,
  output vga_cnt_t vcount,
  output logic     pix_en,
  output logic     hsync_n,
  output logic     vsync_n,
  output logic     active,
  output logic     line_start,
  output logic     frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam vga_cnt_t H_LAST = vga_cnt_t'(H_TOTAL - 1);
  localparam vga_cnt_t V_LAST = vga_cnt_t'(V_TOTAL - 1);

  generate
    if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_total
      $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
    end
  endgenerate

  logic     tick;
  vga_cnt_t h_next;
  vga_cnt_t v_next;

  pix_strobe #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_strobe (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick),
    .pix_en (pix_en)
  );

  // Next raster position: horizontal wrap carries into the line counter,
  // and a wrap on the last line returns to the top of the frame.
  always_comb begin
    h_next = hcount;
    v_next = vcount;
    if (hcount == H_LAST) begin
      h_next = '0;
      if (vcount == V_LAST) begin
        v_next = '0;
      end else begin
        v_next = vcount + 1'b1;
      end
    end else begin
      h_next = hcount + 1'b1;
    end
  end

  // Counters and flags update together from the next position so flags
  // carry no skew; start pulses only live for the strobe cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount      <= H_LAST;
      vcount      <= V_LAST;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      active      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (tick) begin
      hcount      <= h_next;
      vcount      <= v_next;
      hsync_n     <= !in_window(h_next, HS_START, HS_END);
      vsync_n     <= !in_window(v_next, VS_START, VS_END);
      active      <= in_window(h_next, 0, H_ACTIVE) && in_window(v_next, 0, V_ACTIVE);
      line_start  <= (h_next == '0);
      frame_start <= (h_next == '0) && (v_next == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing for reset/cadence/line,
// a tiny raster (CLK_DIV=3) for whole-frame and mid-frame reset, and a
// 1024-wide raster (CLK_DIV=1) for the counter-range edge.
module tb_vga_timing_gen;

  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst_d = 1'b0;
  logic rst_s = 1'b0;
  logic rst_w = 1'b0;

  int checks = 0;
  int passed = 0;

  vga_cnt_t d_h, d_v, s_h, s_v, w_h, w_v;
  logic d_pix, d_hs, d_vs, d_act, d_ls, d_fs;
  logic s_pix, s_hs, s_vs, s_act, s_ls, s_fs;
  logic w_pix, w_hs, w_vs, w_act, w_ls, w_fs;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk (clk), .rst_n (rst_d), .hcount (d_h), .vcount (d_v), .pix_en (d_pix),
    .hsync_n (d_hs), .vsync_n (d_vs), .active (d_act),
    .line_start (d_ls), .frame_start (d_fs)
  );

  // Tiny raster: H 8/2/3/3 (total 16, hsync 10..12), V 6/1/2/2 (total 11, vsync 7..8)
  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (2), .CLK_DIV (3)
  ) dut_s (
    .clk (clk), .rst_n (rst_s), .hcount (s_h), .vcount (s_v), .pix_en (s_pix),
    .hsync_n (s_hs), .vsync_n (s_vs), .active (s_act),
    .line_start (s_ls), .frame_start (s_fs)
  );

  // Full-range raster: H_TOTAL = 1024, V_TOTAL = 628
  vga_timing_gen #(
    .H_ACTIVE (800), .H_FP (40), .H_SYNC (128), .H_BP (56),
    .V_ACTIVE (600), .V_FP (1), .V_SYNC (4), .V_BP (23), .CLK_DIV (1)
  ) dut_w (
    .clk (clk), .rst_n (rst_w), .hcount (w_h), .vcount (w_v), .pix_en (w_pix),
    .hsync_n (w_hs), .vsync_n (w_vs), .active (w_act),
    .line_start (w_ls), .frame_start (w_fs)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed == expected) passed++;
    else $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic r_d, input logic r_s, input logic r_w);
    rst_d = r_d;
    rst_s = r_s;
    rst_w = r_w;
  endtask

  // One rising edge, then sample point at the following falling edge
  task automatic stepClk();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int cnt, prev, strobes, act_cnt, hs_cnt, vs_cnt, ls_cnt, fs_cnt;
    int first_inact, hs_first, hs_last, vs_min, vs_max, prev_h, prev_v, max_h;
    int found, bad;

    // ---------------- default timing: reset ----------------
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (5) stepClk();
    checkOutput("rst_hcount", d_h, 799);
    checkOutput("rst_vcount", d_v, 524);
    checkOutput("rst_hsync_n", d_hs, 1);
    checkOutput("rst_vsync_n", d_vs, 1);
    checkOutput("rst_active", d_act, 0);
    checkOutput("rst_pix_en", d_pix, 0);
    checkOutput("rst_starts", {d_ls, d_fs}, 0);

    applyStimulus(1'b1, 1'b0, 1'b0);
    stepClk();
    checkOutput("edge1_pix_en", d_pix, 0);
    checkOutput("edge1_hcount", d_h, 799);
    stepClk();
    checkOutput("edge2_pix_en", d_pix, 1);
    checkOutput("edge2_pos", {22'd0, d_v, d_h}, 0);
    checkOutput("edge2_frame_start", d_fs, 1);
    checkOutput("edge2_line_start", d_ls, 1);
    checkOutput("edge2_active", d_act, 1);

    // ---------------- strobe cadence over 1000 clks ----------------
    cnt = 0; prev = 1; bad = 0;
    for (int i = 0; i < 1000; i++) begin
      stepClk();
      if (d_pix) cnt++;
      if (int'(d_pix) == prev) bad++;
      prev = d_pix;
    end
    checkOutput("cadence_strobes", cnt, 500);
    checkOutput("cadence_not_alternating", bad, 0);
    checkOutput("cadence_hcount", d_h, 500);
    checkOutput("cadence_fs_clear", d_fs, 0);

    // ---------------- rest of line 0 and wrap ----------------
    first_inact = -1; hs_cnt = 0; hs_first = -1; hs_last = -1; ls_cnt = 0;
    prev_h = d_h; found = 0;
    for (int i = 0; i < 700 && found == 0; i++) begin
      stepClk();
      if (d_pix) begin
        if (d_h == 0) begin
          found = 1;
          checkOutput("wrap_prev_hcount", prev_h, 799);
          checkOutput("wrap_vcount", d_v, 1);
          checkOutput("wrap_line_start", d_ls, 1);
          checkOutput("wrap_frame_start", d_fs, 0);
        end else begin
          if (!d_act && first_inact < 0) first_inact = d_h;
          if (!d_hs) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = d_h;
            hs_last = d_h;
          end
          if (d_ls) ls_cnt++;
          prev_h = d_h;
        end
      end
    end
    checkOutput("line_wrap_found", found, 1);
    checkOutput("active_drop_hcount", first_inact, 640);
    checkOutput("hsync_width", hs_cnt, 96);
    checkOutput("hsync_first", hs_first, 656);
    checkOutput("hsync_last", hs_last, 751);
    checkOutput("spurious_line_start", ls_cnt, 0);

    // ---------------- tiny raster: first strobe with CLK_DIV=3 ----------------
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0);
    cnt = 0;
    for (int i = 0; i < 2; i++) begin
      stepClk();
      if (s_pix) cnt++;
    end
    checkOutput("s_early_pix_en", cnt, 0);
    stepClk();
    checkOutput("s_edge3_pix_en", s_pix, 1);
    checkOutput("s_edge3_pos", {22'd0, s_v, s_h}, 0);
    checkOutput("s_edge3_frame_start", s_fs, 1);

    // ---------------- tiny raster: one whole frame ----------------
    cnt = 0; strobes = 0; act_cnt = 0; hs_cnt = 0; vs_cnt = 0; ls_cnt = 0;
    vs_min = -1; vs_max = -1; prev_h = s_h; prev_v = s_v; found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      stepClk();
      cnt++;
      if (s_pix) begin
        strobes++;
        if (s_act) act_cnt++;
        if (!s_hs) hs_cnt++;
        if (!s_vs) begin
          vs_cnt++;
          if (vs_min < 0) vs_min = s_v;
          vs_max = s_v;
        end
        if (s_ls) ls_cnt++;
        if (s_fs) begin
          found = 1;
          checkOutput("s_wrap_prev", prev_v * 100 + prev_h, 1015);
          checkOutput("s_wrap_pos", {22'd0, s_v, s_h}, 0);
        end else begin
          prev_h = s_h;
          prev_v = s_v;
        end
      end
    end
    checkOutput("s_frame_found", found, 1);
    checkOutput("s_frame_clks", cnt, 528);
    checkOutput("s_frame_strobes", strobes, 176);
    checkOutput("s_active_strobes", act_cnt, 48);
    checkOutput("s_hsync_strobes", hs_cnt, 33);
    checkOutput("s_vsync_strobes", vs_cnt, 32);
    checkOutput("s_vsync_first_line", vs_min, 7);
    checkOutput("s_vsync_last_line", vs_max, 8);
    checkOutput("s_line_starts", ls_cnt, 11);

    // ---------------- tiny raster: async reset mid-frame ----------------
    found = 0;
    for (int i = 0; i < 600 && found == 0; i++) begin
      stepClk();
      if (s_pix && s_h == 5 && s_v == 4) found = 1;
    end
    checkOutput("s_reach_5_4", found, 1);
    checkOutput("s_pre_reset_active", s_act, 1);
    #2;
    applyStimulus(1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("s_async_hcount", s_h, 15);
    checkOutput("s_async_vcount", s_v, 10);
    checkOutput("s_async_pix_en", s_pix, 0);
    checkOutput("s_async_active", s_act, 0);
    repeat (2) stepClk();
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (3) stepClk();
    checkOutput("s_restart_pix_en", s_pix, 1);
    checkOutput("s_restart_pos", {22'd0, s_v, s_h}, 0);
    checkOutput("s_restart_frame_start", s_fs, 1);

    // ---------------- 1024-wide raster, CLK_DIV=1 ----------------
    checkOutput("w_rst_hcount", w_h, 1023);
    checkOutput("w_rst_vcount", w_v, 627);
    applyStimulus(1'b1, 1'b1, 1'b1);
    stepClk();
    checkOutput("w_edge1_pix_en", w_pix, 1);
    checkOutput("w_edge1_pos", {22'd0, w_v, w_h}, 0);
    bad = 0; max_h = 0; found = 0; prev_h = w_h;
    for (int i = 0; i < 1100; i++) begin
      stepClk();
      if (!w_pix) bad++;
      if (int'(w_h) > max_h) max_h = w_h;
      if (prev_h == 1023 && found == 0) begin
        found = 1;
        checkOutput("w_wrap_pos", w_v * 10000 + w_h, 10000);
        checkOutput("w_wrap_line_start", w_ls, 1);
      end
      prev_h = w_h;
    end
    checkOutput("w_pix_en_low_cycles", bad, 0);
    checkOutput("w_max_hcount", max_h, 1023);
    checkOutput("w_wrap_found", found, 1);

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
